// File: rtl/gray_pkg.sv
// Shared pointer types and helpers for the Gray-coded FIFO pointer controller.
package gray_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned PTR_W          = DEF_ADDR_WIDTH + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Full when the pointers differ only in the wrap bit above the address bits.
  function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                    input int unsigned aw);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << (aw + 32'd1)) - 32'd1;
    diff = (wr ^ rd) & mask;
    return (diff == (32'd1 << aw));
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary-to-reflected-Gray converter.
module binary_to_gray #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_ptr_ctrl_chk.sv
// Invariant checker for gray_ptr_ctrl; observes outputs on the falling edge.
module gray_ptr_ctrl_chk #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  input logic [ADDR_WIDTH:0] wr_ptr_gray,
  input logic [ADDR_WIDTH:0] rd_ptr_gray,
  input logic [ADDR_WIDTH:0] count,
  input logic                full,
  input logic                empty
);

  logic [ADDR_WIDTH:0] wr_prev_r, rd_prev_r;
  logic                valid_r;

  // Gray steps are single-bit except across a reset or a flush clear.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_prev_r <= {(ADDR_WIDTH+1){1'b0}};
      rd_prev_r <= {(ADDR_WIDTH+1){1'b0}};
      valid_r   <= 1'b0;
    end else begin
      if (valid_r) begin
        a_wr_gray: assert ($onehot0(wr_ptr_gray ^ wr_prev_r));
        a_rd_gray: assert ($onehot0(rd_ptr_gray ^ rd_prev_r));
      end
      a_full_empty: assert (!(full & empty));
      a_count_max:  assert (32'(count) <= (32'd1 << ADDR_WIDTH));
      wr_prev_r <= wr_ptr_gray;
      rd_prev_r <= rd_ptr_gray;
      valid_r   <= ~flush;
    end
  end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller: gated push/pop, occupancy flags and
// registered Gray pointers for a downstream clock-domain crossing.
module gray_ptr_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_req,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_req,
  output logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam int unsigned W = ADDR_WIDTH + 1;

  logic [W-1:0] wr_ptr_r, rd_ptr_r;
  logic [W-1:0] wr_nxt_s, rd_nxt_s;
  logic [W-1:0] wr_gray_nxt_s, rd_gray_nxt_s;
  logic [W-1:0] wr_gray_r, rd_gray_r;
  logic [W-1:0] count_r, count_nxt_s;
  logic         full_r, empty_r, af_r;
  logic         full_nxt_s, empty_nxt_s, af_nxt_s;
  logic         wr_fire_s, rd_fire_s;

  assign wr_ready    = ~full_r & ~flush;
  assign rd_ready    = ~empty_r & ~flush;
  assign wr_addr     = wr_ptr_r[ADDR_WIDTH-1:0];
  assign rd_addr     = rd_ptr_r[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_r;
  assign rd_ptr_gray = rd_gray_r;
  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = af_r;

  // Next-state pointers and the status they imply, so flags carry no lag.
  always_comb begin
    wr_fire_s = wr_req & wr_ready;
    rd_fire_s = rd_req & rd_ready;
    if (flush) begin
      wr_nxt_s = {W{1'b0}};
      rd_nxt_s = {W{1'b0}};
    end else begin
      wr_nxt_s = wr_ptr_r + {{(W-1){1'b0}}, wr_fire_s};
      rd_nxt_s = rd_ptr_r + {{(W-1){1'b0}}, rd_fire_s};
    end
    count_nxt_s = wr_nxt_s - rd_nxt_s;
    full_nxt_s  = ptr_full(32'(wr_nxt_s), 32'(rd_nxt_s), ADDR_WIDTH);
    empty_nxt_s = (wr_nxt_s == rd_nxt_s);
    af_nxt_s    = (32'(count_nxt_s) >= 32'(AF_LEVEL));
  end

  binary_to_gray #(.WIDTH(W)) u_wr_b2g (.bin(wr_nxt_s), .gray(wr_gray_nxt_s));
  binary_to_gray #(.WIDTH(W)) u_rd_b2g (.bin(rd_nxt_s), .gray(rd_gray_nxt_s));

  // Pointer, Gray and status state registered together on every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {W{1'b0}};
      rd_ptr_r  <= {W{1'b0}};
      wr_gray_r <= {W{1'b0}};
      rd_gray_r <= {W{1'b0}};
      count_r   <= {W{1'b0}};
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      af_r      <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_nxt_s;
      rd_ptr_r  <= rd_nxt_s;
      wr_gray_r <= wr_gray_nxt_s;
      rd_gray_r <= rd_gray_nxt_s;
      count_r   <= count_nxt_s;
      full_r    <= full_nxt_s;
      empty_r   <= empty_nxt_s;
      af_r      <= af_nxt_s;
    end
  end

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed self-checking bench for gray_ptr_ctrl (ADDR_WIDTH=4, AF_LEVEL=12).
module tb_gray_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_ready, rd_ready, full, empty, almost_full;
  logic [3:0] wr_addr, rd_addr;
  logic [4:0] wr_ptr_gray, rd_ptr_gray, count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full)
  );

  gray_ptr_ctrl_chk #(.ADDR_WIDTH(4)) chk (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .count(count), .full(full), .empty(empty)
  );

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d af=%b want 1 0 0 0",
               empty, full, count, almost_full);
    end
    checks++;
    if (wr_ptr_gray !== 5'b00000 || rd_ptr_gray !== 5'b00000) begin
      errors++;
      $display("FAIL reset_gray: wr=%b rd=%b want 00000 00000", wr_ptr_gray, rd_ptr_gray);
    end
    checks++;
    if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: wr_ready=%b rd_ready=%b want 1 0", wr_ready, rd_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    wr_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (count !== 5'(i) || almost_full !== (i >= 12)) begin
        errors++;
        $display("FAIL fill_count: push %0d count=%0d af=%b want %0d %b",
                 i, count, almost_full, i, (i >= 12));
      end
    end
    checks++;
    if (full !== 1'b1 || wr_ptr_gray !== 5'b11000 || wr_addr !== 4'd0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b gray=%b addr=%0d wr_ready=%b want 1 11000 0 0",
               full, wr_ptr_gray, wr_addr, wr_ready);
    end
    tick();
    checks++;
    if (count !== 5'd16 || wr_ptr_gray !== 5'b11000) begin
      errors++;
      $display("FAIL fill_push17: count=%0d gray=%b want 16 11000", count, wr_ptr_gray);
    end
    wr_req = 1'b0;
  endtask

  task automatic test_drain();
    rd_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (count !== 5'(16 - i) || empty !== (i == 16)) begin
        errors++;
        $display("FAIL drain_count: pop %0d count=%0d empty=%b want %0d %b",
                 i, count, empty, 16 - i, (i == 16));
      end
    end
    checks++;
    if (rd_ptr_gray !== 5'b11000 || rd_ready !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: gray=%b rd_ready=%b full=%b want 11000 0 0",
               rd_ptr_gray, rd_ready, full);
    end
    tick();
    checks++;
    if (count !== 5'd0 || rd_ptr_gray !== 5'b11000 || rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL drain_pop17: count=%0d gray=%b addr=%0d want 0 11000 0",
               count, rd_ptr_gray, rd_addr);
    end
    rd_req = 1'b0;
  endtask

  // Pointers enter at wr=rd=16; five pushes then 40 cycles of push+pop.
  task automatic test_back_to_back();
    logic [4:0] wprev, rprev;
    bit wrap_seen = 1'b0;
    wr_req = 1'b1;
    repeat (5) tick();
    rd_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      wprev = wr_ptr_gray;
      rprev = rd_ptr_gray;
      tick();
      checks++;
      if (count !== 5'd5 || wr_addr !== 4'((21 + k) % 16) || rd_addr !== 4'((16 + k) % 16)) begin
        errors++;
        $display("FAIL b2b_count: k=%0d count=%0d wa=%0d ra=%0d want 5 %0d %0d",
                 k, count, wr_addr, rd_addr, (21 + k) % 16, (16 + k) % 16);
      end
      checks++;
      if (wr_ptr_gray !== g((21 + k) % 32) || rd_ptr_gray !== g((16 + k) % 32) ||
          $countones(wr_ptr_gray ^ wprev) != 1 || $countones(rd_ptr_gray ^ rprev) != 1) begin
        errors++;
        $display("FAIL b2b_gray: k=%0d wr=%b rd=%b want %b %b", k, wr_ptr_gray, rd_ptr_gray,
                 g((21 + k) % 32), g((16 + k) % 32));
      end
      if (wr_addr == 4'd0 && wprev[4] != wr_ptr_gray[4]) wrap_seen = 1'b1;
    end
    checks++;
    if (!wrap_seen) begin
      errors++;
      $display("FAIL b2b_wrap: msb toggle at addr wrap seen=%b want 1", wrap_seen);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Enters with wr=29, rd=24 (count 5).
  task automatic test_full_empty();
    wr_req = 1'b1;
    repeat (11) tick();
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL fe_fill: full=%b count=%0d want 1 16", full, count);
    end
    rd_req = 1'b1;
    tick();
    checks++;
    if (count !== 5'd15 || full !== 1'b0 || wr_ptr_gray !== g(8) || rd_ptr_gray !== g(25)) begin
      errors++;
      $display("FAIL fe_full_both: count=%0d full=%b wg=%b rg=%b want 15 0 %b %b",
               count, full, wr_ptr_gray, rd_ptr_gray, g(8), g(25));
    end
    wr_req = 1'b0;
    repeat (15) tick();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL fe_drain: empty=%b count=%0d want 1 0", empty, count);
    end
    wr_req = 1'b1;
    tick();
    checks++;
    if (count !== 5'd1 || empty !== 1'b0 || rd_ptr_gray !== g(8) || wr_ptr_gray !== g(9)) begin
      errors++;
      $display("FAIL fe_empty_both: count=%0d empty=%b rg=%b wg=%b want 1 0 %b %b",
               count, empty, rd_ptr_gray, wr_ptr_gray, g(8), g(9));
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL fe_last_pop: count=%0d empty=%b want 0 1", count, empty);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_flush_reset();
    wr_req = 1'b1;
    repeat (7) tick();
    checks++;
    if (count !== 5'd7) begin
      errors++;
      $display("FAIL flush_pre: count=%0d want 7", count);
    end
    flush = 1'b1;
    rd_req = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: wr_ready=%b rd_ready=%b want 0 0", wr_ready, rd_ready);
    end
    tick();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0 ||
        wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d empty=%b wg=%b rg=%b wa=%0d ra=%0d want 0 1 0 0 0 0",
               count, empty, wr_ptr_gray, rd_ptr_gray, wr_addr, rd_addr);
    end
    flush = 1'b0;
    rd_req = 1'b0;
    repeat (7) tick();
    checks++;
    if (count !== 5'd7 || wr_ptr_gray !== g(7)) begin
      errors++;
      $display("FAIL refill: count=%0d wg=%b want 7 %b", count, wr_ptr_gray, g(7));
    end
    rd_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ptr_gray !== 5'd0 ||
        rd_ptr_gray !== 5'd0 || wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b wg=%b rg=%b wa=%0d want 0 1 0 0 0 0",
               count, empty, full, wr_ptr_gray, rd_ptr_gray, wr_addr);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: count=%0d empty=%b wr_ready=%b want 0 1 1",
               count, empty, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
